// File: rtl/serial_add_ctrl_if.sv
// rtl/serial_add_ctrl_if.sv - operand/result bundle for the bit-serial adder
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carry;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    modport master (
        output start, a, b,
        input  busy, done, sum, carry
`ifdef SERIAL_ADD_OVF_EN
        , input ovf
`endif
    );

    modport slave (
        input  start, a, b,
        output busy, done, sum, carry
`ifdef SERIAL_ADD_OVF_EN
        , output ovf
`endif
    );
endinterface

// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial a+b through one shared full-adder cell, LSB first
// Optional signed-overflow flag enabled by macro SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    serial_add_ctrl_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, carry_q, carry_d;
    logic             ha0_s, ha0_c, ha1_c, s_bit, c_out;
`ifdef SERIAL_ADD_OVF_EN
    logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d, ovf_q, ovf_d;
`endif

    // Shared one-bit cell: two half adders plus OR.
    assign ha0_s = a_q[0] ^ b_q[0];
    assign ha0_c = a_q[0] & b_q[0];
    assign s_bit = ha0_s ^ c_q;
    assign ha1_c = ha0_s & c_q;
    assign c_out = ha0_c | ha1_c;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        sum_d   = sum_q;
        carry_d = carry_q;
`ifdef SERIAL_ADD_OVF_EN
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = RUN;
`ifdef SERIAL_ADD_OVF_EN
                    a_msb_d = bus.a[WIDTH-1];
                    b_msb_d = bus.b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = {s_bit, res_q[WIDTH-1:1]};
                c_d   = c_out;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    sum_d   = {s_bit, res_q[WIDTH-1:1]};
                    carry_d = c_out;
`ifdef SERIAL_ADD_OVF_EN
                    // s_bit of the last step is the result sign bit.
                    ovf_d   = (a_msb_q == b_msb_q) && (s_bit != a_msb_q);
`endif
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            c_q     <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
`ifdef SERIAL_ADD_OVF_EN
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.sum   = sum_q;
    assign bus.carry = carry_q;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf   = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - randomized self-checking bench for serial_add_ctrl
module tb_serial_add_ctrl;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();
    serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] exp_prev;
    logic         exp_prev_c;
    logic         exp_prev_o;

    int           busy_cnt, done_at, done_cnt;
    logic [W-1:0] o_sum, sum_first;
    logic         o_carry, o_ovf, stable;

    function automatic logic [W-1:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y);
        longint t = longint'(x) + longint'(y);
        return W'(t % (longint'(1) << W));
    endfunction

    function automatic logic ref_carry(input logic [W-1:0] x, input logic [W-1:0] y);
        return (longint'(x) + longint'(y)) >= (longint'(1) << W);
    endfunction

    function automatic longint as_signed(input logic [W-1:0] x);
        longint v = longint'(x);
        return (v >= (longint'(1) << (W - 1))) ? v - (longint'(1) << W) : v;
    endfunction

    function automatic logic ref_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
        longint s = as_signed(x) + as_signed(y);
        return (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
    endfunction

    // Runs one addition, recording what the DUT did over the W+2 edges after acceptance.
    task automatic drive_add(input logic [W-1:0] av, input logic [W-1:0] bv,
                             input bit keep_start, input bit perturb);
        @(negedge clk);
        bus.a = av; bus.b = bv; bus.start = 1'b1;
        @(posedge clk); #1;
        if (!keep_start) bus.start = 1'b0;
        busy_cnt = 0; done_at = -1; done_cnt = 0; stable = 1'b1;
        sum_first = bus.sum;
        o_sum = '0; o_carry = 1'b0; o_ovf = 1'b0;
        for (int c = 0; c <= W + 1; c++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c < W && bus.sum !== sum_first) stable = 1'b0;
            if (c == W) begin
                o_sum = bus.sum; o_carry = bus.carry;
`ifdef SERIAL_ADD_OVF_EN
                o_ovf = bus.ovf;
`endif
            end
            if (c <= W) begin
                @(negedge clk);
                if (perturb) begin bus.a = W'($urandom); bus.b = W'($urandom); end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; bus.start = 1'b0; bus.a = '0; bus.b = '0;
        #12;
        n_tests++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_tests++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_tests++; if (bus.sum !== '0) begin n_fail++; $display("FAIL reset_sum got %h want 0", bus.sum); end
        n_tests++; if (bus.carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry got %b want 0", bus.carry); end
`ifdef SERIAL_ADD_OVF_EN
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        exp_prev = '0; exp_prev_c = 1'b0; exp_prev_o = 1'b0;
    endtask

    task automatic test_arith(input int n_rand);
        logic [W-1:0] va[$];
        logic [W-1:0] vb[$];
        logic [W-1:0] es;
        logic         ec, eo;
        va = '{8'h00, 8'hFF, 8'hA5, 8'h7F, 8'h80, 8'h10};
        vb = '{8'h00, 8'h01, 8'h5A, 8'h01, 8'h80, 8'h20};
        for (int i = 0; i < n_rand; i++) begin
            va.push_back(W'($urandom));
            vb.push_back(W'($urandom));
        end
        for (int i = 0; i < va.size(); i++) begin
            drive_add(va[i], vb[i], 1'b0, 1'b0);
            es = ref_sum(va[i], vb[i]); ec = ref_carry(va[i], vb[i]); eo = ref_ovf(va[i], vb[i]);
            n_tests++; if (busy_cnt !== W) begin n_fail++; $display("FAIL arith_busy_cycles %h+%h got %0d want %0d", va[i], vb[i], busy_cnt, W); end
            n_tests++; if (done_at !== W) begin n_fail++; $display("FAIL arith_done_latency %h+%h got %0d want %0d", va[i], vb[i], done_at, W); end
            n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL arith_done_width %h+%h got %0d want 1", va[i], vb[i], done_cnt); end
            n_tests++; if (sum_first !== exp_prev || !stable) begin n_fail++; $display("FAIL arith_sum_hold %h+%h got %h stable=%b want %h", va[i], vb[i], sum_first, stable, exp_prev); end
            n_tests++; if (o_sum !== es) begin n_fail++; $display("FAIL arith_sum %h+%h got %h want %h", va[i], vb[i], o_sum, es); end
            n_tests++; if (o_carry !== ec) begin n_fail++; $display("FAIL arith_carry %h+%h got %b want %b", va[i], vb[i], o_carry, ec); end
`ifdef SERIAL_ADD_OVF_EN
            n_tests++; if (o_ovf !== eo) begin n_fail++; $display("FAIL arith_ovf %h+%h got %b want %b", va[i], vb[i], o_ovf, eo); end
`endif
            exp_prev = es; exp_prev_c = ec; exp_prev_o = eo;
        end
    endtask

    task automatic test_hold_idle();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); bus.a = W'($urandom); bus.b = W'($urandom);
            @(posedge clk); #1;
            n_tests++; if (bus.sum !== exp_prev || bus.carry !== exp_prev_c) begin
                n_fail++; $display("FAIL idle_hold got %h/%b want %h/%b", bus.sum, bus.carry, exp_prev, exp_prev_c); end
`ifdef SERIAL_ADD_OVF_EN
            n_tests++; if (bus.ovf !== exp_prev_o) begin n_fail++; $display("FAIL idle_hold_ovf got %b want %b", bus.ovf, exp_prev_o); end
`endif
        end
    endtask

    task automatic test_start_held();
        logic [W-1:0] xa, xb, es;
        for (int k = 0; k < 3; k++) begin
            xa = W'($urandom); xb = W'($urandom);
            drive_add(xa, xb, 1'b1, 1'b1);
            es = ref_sum(xa, xb);
            n_tests++; if (busy_cnt !== W) begin n_fail++; $display("FAIL held_busy_cycles run%0d got %0d want %0d", k, busy_cnt, W); end
            n_tests++; if (done_at !== W) begin n_fail++; $display("FAIL held_done_latency run%0d got %0d want %0d", k, done_at, W); end
            n_tests++; if (o_sum !== es || o_carry !== ref_carry(xa, xb)) begin
                n_fail++; $display("FAIL held_result %h+%h got %h/%b want %h/%b", xa, xb, o_sum, o_carry, es, ref_carry(xa, xb)); end
            exp_prev = es; exp_prev_c = ref_carry(xa, xb); exp_prev_o = ref_ovf(xa, xb);
        end
        @(negedge clk); bus.start = 1'b0;
        repeat (W + 3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_run();
        drive_add(8'h11, 8'h22, 1'b0, 1'b0);
        @(negedge clk); bus.a = 8'hC3; bus.b = 8'h5E; bus.start = 1'b1;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1; rst_n = 1'b0; #1;
        n_tests++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL midrst_flags got busy=%b done=%b want 0/0", bus.busy, bus.done); end
        n_tests++; if (bus.sum !== '0 || bus.carry !== 1'b0) begin n_fail++; $display("FAIL midrst_result got %h/%b want 00/0", bus.sum, bus.carry); end
`ifdef SERIAL_ADD_OVF_EN
        n_tests++; if (bus.ovf !== 1'b0) begin n_fail++; $display("FAIL midrst_ovf got %b want 0", bus.ovf); end
`endif
        @(posedge clk); #1; rst_n = 1'b1;
        exp_prev = '0; exp_prev_c = 1'b0; exp_prev_o = 1'b0;
        done_cnt = 0;
        repeat (W + 2) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_cnt++;
        end
        n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL midrst_no_done got %0d active cycles want 0", done_cnt); end
        drive_add(8'h03, 8'h04, 1'b0, 1'b0);
        n_tests++; if (busy_cnt !== W || done_at !== W) begin n_fail++; $display("FAIL midrst_restart_timing got busy=%0d done_at=%0d want %0d/%0d", busy_cnt, done_at, W, W); end
        n_tests++; if (sum_first !== 8'h00) begin n_fail++; $display("FAIL midrst_restart_prev got %h want 00", sum_first); end
        n_tests++; if (o_sum !== 8'h07 || o_carry !== 1'b0) begin n_fail++; $display("FAIL midrst_restart_sum got %h/%b want 07/0", o_sum, o_carry); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        test_reset();
        test_arith(25);
        test_hold_idle();
        test_start_held();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
